// File: rtl/day6_problem_sequencer.sv
// Iterative worksheet evaluator: accepts one problem record per handshake, reduces it
// one operand per cycle with a shared add/multiply unit, and accumulates a grand total.
module day6_problem_sequencer #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_OPERANDS = 4,
  parameter int RESULT_WIDTH = 64,
  parameter int MAX_PROBLEMS = 1000,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NUM_OPERANDS*DATA_WIDTH-1:0] in_operands,
  input  logic                               in_op,
  input  logic                               in_last,
  output logic                               busy,
  output logic [COUNT_WIDTH-1:0]             problem_count,
  output logic                               finished,
  output logic                               overrun,
  output logic [RESULT_WIDTH-1:0]            result
);

  localparam int K_W = (NUM_OPERANDS > 2) ? $clog2(NUM_OPERANDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EVAL,
    S_ACCUM,
    S_DONE
  } state_e;

  state_e                            state_q, state_d;
  logic [RESULT_WIDTH-1:0]           acc_q, acc_d;
  logic [RESULT_WIDTH-1:0]           result_q, result_d;
  logic [COUNT_WIDTH-1:0]            count_q, count_d;
  logic                              finished_q, finished_d;
  logic                              overrun_q, overrun_d;
  logic [K_W-1:0]                    k_q, k_d;
  logic [RESULT_WIDTH-1:0]           partial_q, partial_d;
  logic [NUM_OPERANDS*DATA_WIDTH-1:0] opnds_q, opnds_d;
  logic                              op_q, op_d;
  logic                              last_q, last_d;

  logic [DATA_WIDTH-1:0]   opnd_cur;
  logic [RESULT_WIDTH-1:0] mul_operand;
  logic [RESULT_WIDTH-1:0] acc_sum;
  logic [COUNT_WIDTH-1:0]  count_inc;

  assign opnd_cur    = opnds_q[int'(k_q)*DATA_WIDTH +: DATA_WIDTH];
  // A zero operand is a blank worksheet column, so it multiplies as identity.
  assign mul_operand = (opnd_cur == '0) ? RESULT_WIDTH'(1) : RESULT_WIDTH'(opnd_cur);
  assign acc_sum     = acc_q + partial_q;
  assign count_inc   = count_q + COUNT_WIDTH'(1);

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    result_d   = result_q;
    count_d    = count_q;
    finished_d = finished_q;
    overrun_d  = overrun_q;
    k_d        = k_q;
    partial_d  = partial_q;
    opnds_d    = opnds_q;
    op_d       = op_q;
    last_d     = last_q;
    in_ready   = 1'b0;
    busy       = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          acc_d      = '0;
          count_d    = '0;
          finished_d = 1'b0;
          overrun_d  = 1'b0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          opnds_d   = in_operands;
          op_d      = in_op;
          last_d    = in_last;
          partial_d = in_op ? '0 : RESULT_WIDTH'(1);
          k_d       = '0;
          state_d   = S_EVAL;
        end
      end
      S_EVAL: begin
        busy      = 1'b1;
        partial_d = op_q ? (partial_q + RESULT_WIDTH'(opnd_cur)) : (partial_q * mul_operand);
        k_d       = k_q + K_W'(1);
        if (k_q == K_W'(NUM_OPERANDS - 1)) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        busy    = 1'b1;
        acc_d   = acc_sum;
        count_d = count_inc;
        if (last_q || (count_inc == COUNT_WIDTH'(MAX_PROBLEMS))) begin
          result_d   = acc_sum;
          finished_d = 1'b1;
          overrun_d  = ~last_q;
          state_d    = S_DONE;
        end else begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      result_q   <= '0;
      count_q    <= '0;
      finished_q <= 1'b0;
      overrun_q  <= 1'b0;
      k_q        <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      count_q    <= count_d;
      finished_q <= finished_d;
      overrun_q  <= overrun_d;
      k_q        <= k_d;
    end
  end

  // NOTE: the record latch is pure datapath, always written in FETCH before it is
  // read, so it carries no reset.
  always_ff @(posedge clk) begin
    partial_q <= partial_d;
    opnds_q   <= opnds_d;
    op_q      <= op_d;
    last_q    <= last_d;
  end

  assign problem_count = count_q;
  assign finished      = finished_q;
  assign overrun       = overrun_q;
  assign result        = result_q;

endmodule

// File: tb/tb_day6_problem_sequencer.sv
// Scoreboard bench for day6_problem_sequencer: expected run totals are queued as records
// are accepted and compared when finished rises.
module tb_day6_problem_sequencer;

  localparam int DW   = 16;
  localparam int NO   = 4;
  localparam int RW   = 64;
  localparam int MAXP = 3;
  localparam int CW   = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [NO*DW-1:0]  in_operands;
  logic              in_op;
  logic              in_last;
  logic              busy;
  logic [CW-1:0]     problem_count;
  logic              finished;
  logic              overrun;
  logic [RW-1:0]     result;

  always #5 clk = ~clk;

  day6_problem_sequencer #(
    .DATA_WIDTH  (DW),
    .NUM_OPERANDS(NO),
    .RESULT_WIDTH(RW),
    .MAX_PROBLEMS(MAXP),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_operands  (in_operands),
    .in_op        (in_op),
    .in_last      (in_last),
    .busy         (busy),
    .problem_count(problem_count),
    .finished     (finished),
    .overrun      (overrun),
    .result       (result)
  );

  typedef struct packed {
    logic [RW-1:0] total;
    logic [CW-1:0] count;
    logic          ovr;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [RW-1:0] m_total;
  int            m_count;
  logic          fin_prev = 1'b0;

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [NO*DW-1:0] pack4(input logic [DW-1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [RW-1:0] model_value(input logic [NO*DW-1:0] ops, input logic is_add);
    logic [RW-1:0] p;
    logic [DW-1:0] o;
    p = is_add ? '0 : RW'(1);
    for (int k = 0; k < NO; k++) begin
      o = ops[k*DW +: DW];
      if (is_add) p = p + RW'(o);
      else        p = p * ((o == '0) ? RW'(1) : RW'(o));
    end
    return p;
  endfunction

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    m_total = '0;
    m_count = 0;
  endtask

  // Offers one record for up to max_wait cycles; gap counts cycles in_ready stayed low.
  task automatic send(input logic [NO*DW-1:0] ops, input logic is_add, input logic last,
                      input int max_wait, output bit acc, output int gap);
    exp_t e;
    @(negedge clk);
    in_operands = ops;
    in_op       = is_add;
    in_last     = last;
    in_valid    = 1'b1;
    acc         = 1'b0;
    gap         = 0;
    while (!acc && gap < max_wait) begin
      if (in_ready) begin
        @(posedge clk);
        acc = 1'b1;
        #1 in_valid = 1'b0;
      end else begin
        gap++;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    if (acc) begin
      m_total = m_total + model_value(ops, is_add);
      m_count++;
      if (last || m_count == MAXP) begin
        e.total = m_total;
        e.count = CW'(m_count);
        e.ovr   = !last && (m_count == MAXP);
        sb.push_back(e);
      end
    end
  endtask

  task automatic wait_finished(input string tag, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!finished && lat < 50);
    check(tag, finished, 1'b1);
  endtask

  always @(negedge clk) begin
    if (finished && !fin_prev) begin
      check("sb_pending", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("result", result, mon_e.total);
        check("problem_count", problem_count, RW'(mon_e.count));
        check("overrun", overrun, mon_e.ovr);
      end
    end
    fin_prev <= finished;
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_finished"}, finished, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_count"}, problem_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit acc;
    int gap;
    int lat;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    in_op = 1'b0; in_last = 1'b0; in_operands = '0;
    m_total = '0; m_count = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // 1: single multiply record, latency to finished
    do_start();
    check("t1_ready_in_fetch", in_ready, 1'b1);
    send(pack4(123, 45, 6, 0), 1'b0, 1'b1, 20, acc, gap);
    check("t1_accept", acc, 1'b1);
    wait_finished("t1_finished", lat);
    check("t1_latency", lat, 6);

    // 2: mul then add, back-to-back gap
    do_start();
    send(pack4(123, 45, 6, 0), 1'b0, 1'b0, 20, acc, gap);
    check("t2_accept1", acc, 1'b1);
    send(pack4(328, 64, 98, 0), 1'b1, 1'b1, 20, acc, gap);
    check("t2_accept2", acc, 1'b1);
    check("t2_gap", gap, 5);
    wait_finished("t2_finished", lat);

    // 3: wrapping products; a start pulse mid-evaluation must be ignored
    do_start();
    send(pack4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 1'b0, 1'b0, 20, acc, gap);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    send(pack4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 1'b0, 1'b1, 20, acc, gap);
    check("t3_accept2", acc, 1'b1);
    wait_finished("t3_finished", lat);

    // 4: all-blank columns
    do_start();
    send(pack4(0, 0, 0, 0), 1'b0, 1'b1, 20, acc, gap);
    wait_finished("t4_mul_finished", lat);
    do_start();
    send(pack4(0, 0, 0, 0), 1'b1, 1'b1, 20, acc, gap);
    wait_finished("t4_add_finished", lat);

    // 5: overrun at MAX_PROBLEMS, fourth record refused
    do_start();
    for (int i = 0; i < MAXP; i++) begin
      send(pack4(1, 0, 0, 0), 1'b1, 1'b0, 20, acc, gap);
      check("t5_accept", acc, 1'b1);
    end
    send(pack4(1, 0, 0, 0), 1'b1, 1'b0, 20, acc, gap);
    check("t5_fourth_refused", acc, 1'b0);
    check("t5_overrun_held", overrun, 1'b1);
    check("t5_not_busy", busy, 1'b0);

    // 6: reset during evaluation of the second record, then a fresh run
    do_start();
    send(pack4(1, 1, 1, 1), 1'b1, 1'b0, 20, acc, gap);
    send(pack4(1, 1, 1, 1), 1'b1, 1'b0, 20, acc, gap);
    check("t6_accept2", acc, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("t6_busy_eval", busy, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_all_zero("t6_reset");
    do_start();
    send(pack4(2, 3, 0, 0), 1'b0, 1'b1, 20, acc, gap);
    wait_finished("t6_finished", lat);

    @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
